// File: rtl/ram_tp_be_32x64_rd_stream.sv
// Read-side streaming controller for the 32x64 two-port bit-enable RAM.
// Issues RAM read strobes for a block of words starting at a base address,
// absorbs the 1-cycle RAM read latency and delivers the words on a
// valid/ready stream through a 2-entry FIFO that sustains 1 word/cycle.
module ram_tp_be_32x64_rd_stream #(
    parameter int ADR_WD = 5,
    parameter int DAT_WD = 64,
    parameter int LEN_WD = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADR_WD-1:0] base_adr_i,
    input  logic [LEN_WD-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_ena_o,
    output logic [ADR_WD-1:0] rd_adr_o,
    input  logic [DAT_WD-1:0] rd_dat_i,
    output logic              dat_vld_o,
    output logic [DAT_WD-1:0] dat_o,
    output logic              last_o,
    input  logic              dat_rdy_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADR_WD-1:0]        adr_q, adr_d;
    logic [LEN_WD-1:0]        issue_cnt_q, issue_cnt_d;
    logic [LEN_WD-1:0]        pop_cnt_q, pop_cnt_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               occ_q, occ_d;
    logic [1:0][DAT_WD-1:0]   fifo_q, fifo_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     done_q, done_d;

    logic                     pop_s;
    logic                     push_s;
    logic                     issue_s;

    // Output views of the state; all except rd_ena_o come straight from flops.
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        done_o    = done_q;
        rd_adr_o  = adr_q;
        dat_vld_o = (occ_q != 2'd0);
        dat_o     = fifo_q[rd_ptr_q];
        last_o    = (occ_q != 2'd0) && (pop_cnt_q == LEN_WD'(1));
        rd_ena_o  = issue_s;
    end

    // Handshake and issue decisions; a read may go out only if its word is
    // guaranteed a FIFO slot, counting this cycle's pop (full-rate path).
    always_comb begin
        pop_s   = (occ_q != 2'd0) && dat_rdy_i;
        push_s  = inflight_q;
        issue_s = (state_q == ST_READ) && (issue_cnt_q != {LEN_WD{1'b0}}) &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
    end

    // Transfer FSM: start latch, address/issue/pop counters and done pulse.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        done_d      = 1'b0;
        if (pop_s) begin
            pop_cnt_d = pop_cnt_q - LEN_WD'(1);
        end else begin
            pop_cnt_d = pop_cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != {LEN_WD{1'b0}}) begin
                        state_d     = ST_READ;
                        adr_d       = base_adr_i;
                        issue_cnt_d = len_i;
                        pop_cnt_d   = len_i;
                    end else begin
                        // Empty transfer: report completion without reading.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    adr_d       = adr_q + ADR_WD'(1);
                    issue_cnt_d = issue_cnt_q - LEN_WD'(1);
                    if (issue_cnt_q == LEN_WD'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (pop_cnt_q == LEN_WD'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry output FIFO; push and pop may coincide at any occupancy.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        inflight_d = issue_s;
        if (push_s) begin
            fifo_d[wr_ptr_q] = rd_dat_i;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // State register; reset clears everything and drops any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= {ADR_WD{1'b0}};
            issue_cnt_q <= {LEN_WD{1'b0}};
            pop_cnt_q   <= {LEN_WD{1'b0}};
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            fifo_q      <= {2{{DAT_WD{1'b0}}}};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_tp_be_32x64_rd_stream.sv
// Self-checking bench for ram_tp_be_32x64_rd_stream: a table of transfers
// with a word scoreboard, plus a hand-written mid-transfer reset sequence.
module tb_ram_tp_be_32x64_rd_stream;

    localparam int ADR_WD    = 5;
    localparam int DAT_WD    = 64;
    localparam int LEN_WD    = 6;
    localparam int RUN_LIMIT = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [ADR_WD-1:0] base_adr_i;
    logic [LEN_WD-1:0] len_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_ena_o;
    logic [ADR_WD-1:0] rd_adr_o;
    logic [DAT_WD-1:0] rd_dat_i;
    logic              dat_vld_o;
    logic [DAT_WD-1:0] dat_o;
    logic              last_o;
    logic              dat_rdy_i;

    // mode: 0 = ready always high, 1 = random ready, 2 = ready low on cycles 6..15
    typedef struct {
        logic [ADR_WD-1:0] base;
        logic [LEN_WD-1:0] len;
        int                mode;
        bit                poke;
        int                exp_lat;
    } vec_t;

    typedef struct {
        logic [DAT_WD-1:0] dat;
        logic              last;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mem [32];
    vec_t        vecs [9];
    vec_t        rv;
    int          n_pass = 0;
    int          n_chk  = 0;
    bit          quiet;

    ram_tp_be_32x64_rd_stream #(
        .ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .LEN_WD(LEN_WD)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_adr_i(base_adr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .rd_ena_o(rd_ena_o),
        .rd_adr_o(rd_adr_o), .rd_dat_i(rd_dat_i), .dat_vld_o(dat_vld_o),
        .dat_o(dat_o), .last_o(last_o), .dat_rdy_i(dat_rdy_i)
    );

    always #5 clk = ~clk;

    // RAM read port model: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        rd_dat_i <= rd_ena_o ? mem[rd_adr_o] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a transfer in the current cycle and follows it to done_o.
    task automatic run(input vec_t v);
        int cyc = 0, done_cyc = -1, first_rd = -1, first_vld = -1;
        int n_rd = 0, n_pop = 0, max_out = 0, win_rd = 0, win_out = -1;
        int len_n;
        bit busy_seen = 1'b0, hold_vld = 1'b0;
        logic [63:0] hold_dat = 64'd0;
        logic hold_last = 1'b0;
        logic [ADR_WD-1:0] exp_adr;
        exp_t e, got;
        len_n   = int'(v.len);
        exp_adr = v.base;
        for (int i = 0; i < len_n; i++) begin
            e.dat  = mem[5'(int'(v.base) + i)];
            e.last = (i == len_n - 1);
            sb_q.push_back(e);
        end
        start_i    = 1'b1;
        base_adr_i = v.base;
        len_i      = v.len;
        dat_rdy_i  = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (done_cyc < 0 && cyc < RUN_LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (v.poke && cyc == 2) begin
                start_i    = 1'b1;
                base_adr_i = 5'd20;
                len_i      = 6'd7;
            end else begin
                start_i = 1'b0;
            end
            case (v.mode)
                1:       dat_rdy_i = 1'($urandom_range(0, 1));
                2:       dat_rdy_i = (cyc >= 6 && cyc <= 15) ? 1'b0 : 1'b1;
                default: dat_rdy_i = 1'b1;
            endcase
            #1;
            if (cyc == 15) win_out = n_rd - n_pop;
            if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
            if (busy_o) busy_seen = 1'b1;
            if (hold_vld) begin
                chk("hold_vld", 64'(dat_vld_o), 64'd1);
                chk("hold_dat", dat_o, hold_dat);
                chk("hold_last", 64'(last_o), 64'(hold_last));
            end
            if (rd_ena_o) begin
                chk("rd_adr", 64'(rd_adr_o), 64'(exp_adr));
                exp_adr++;
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                if (cyc >= 7 && cyc <= 15) win_rd++;
            end
            if (dat_vld_o && first_vld < 0) first_vld = cyc;
            if (dat_vld_o && dat_rdy_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    got = sb_q.pop_front();
                    chk("dat", dat_o, got.dat);
                    chk("last", 64'(last_o), 64'(got.last));
                end
                n_pop++;
            end
            hold_vld  = dat_vld_o && !dat_rdy_i;
            hold_dat  = dat_o;
            hold_last = last_o;
            if (done_o) done_cyc = cyc;
        end
        start_i = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
        if (v.exp_lat > 0) chk("done_lat", 64'(done_cyc), 64'(v.exp_lat));
        chk("n_rd", 64'(n_rd), 64'(len_n));
        chk("n_pop", 64'(n_pop), 64'(len_n));
        chk("busy_seen", 64'(busy_seen), 64'(len_n != 0));
        chk("first_rd", 64'(first_rd), 64'((len_n != 0) ? 1 : -1));
        chk("first_vld", 64'(first_vld), 64'((len_n != 0) ? 3 : -1));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("outstanding_le2", 64'(max_out <= 2), 64'd1);
        if (v.mode == 2) begin
            chk("stall_reads", 64'(win_rd), 64'd0);
            chk("stall_outstanding", 64'(win_out), 64'd2);
        end
        sb_q.delete();
    endtask

    initial begin
        vecs[0] = '{base: 5'd3,  len: 6'd4,  mode: 0, poke: 1'b0, exp_lat: 7};
        vecs[1] = '{base: 5'd30, len: 6'd4,  mode: 0, poke: 1'b0, exp_lat: 7};
        vecs[2] = '{base: 5'd0,  len: 6'd33, mode: 0, poke: 1'b0, exp_lat: 36};
        vecs[3] = '{base: 5'd5,  len: 6'd0,  mode: 0, poke: 1'b0, exp_lat: 1};
        vecs[4] = '{base: 5'd7,  len: 6'd5,  mode: 0, poke: 1'b1, exp_lat: 8};
        vecs[5] = '{base: 5'd9,  len: 6'd32, mode: 1, poke: 1'b0, exp_lat: 0};
        vecs[6] = '{base: 5'd0,  len: 6'd32, mode: 2, poke: 1'b0, exp_lat: 0};
        vecs[7] = '{base: 5'd31, len: 6'd1,  mode: 0, poke: 1'b0, exp_lat: 4};
        vecs[8] = '{base: 5'd12, len: 6'd63, mode: 1, poke: 1'b0, exp_lat: 0};

        for (int i = 0; i < 32; i++) mem[i] = 64'(i);
        rst        = 1'b1;
        start_i    = 1'b0;
        base_adr_i = 5'd0;
        len_i      = 6'd0;
        dat_rdy_i  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_rd_ena", 64'(rd_ena_o), 64'd0);
        chk("rst_rd_adr", 64'(rd_adr_o), 64'd0);
        chk("rst_vld", 64'(dat_vld_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_dat", dat_o, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Back-to-back: each transfer starts in the previous one's done cycle.
        for (int i = 0; i < 9; i++) run(vecs[i]);

        // Reset with one word buffered and one read in flight.
        start_i    = 1'b1;
        base_adr_i = 5'd0;
        len_i      = 6'd20;
        dat_rdy_i  = 1'b0;
        @(posedge clk); #2; start_i = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_rst_vld", 64'(dat_vld_o), 64'd1);
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        chk("mid_rst_rd_ena", 64'(rd_ena_o), 64'd0);
        chk("mid_rst_rd_adr", 64'(rd_adr_o), 64'd0);
        chk("mid_rst_vld", 64'(dat_vld_o), 64'd0);
        chk("mid_rst_last", 64'(last_o), 64'd0);
        chk("mid_rst_dat", dat_o, 64'd0);
        rst       = 1'b0;
        dat_rdy_i = 1'b1;
        quiet     = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
            if (done_o || dat_vld_o || busy_o || rd_ena_o) quiet = 1'b0;
        end
        chk("post_rst_quiet", 64'(quiet), 64'd1);
        for (int i = 0; i < 32; i++) mem[i] = 64'hF00D_0000_0000_0000 | 64'(i);
        rv = '{base: 5'd4, len: 6'd2, mode: 0, poke: 1'b0, exp_lat: 5};
        run(rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
